// File: rtl/pipe_io_pkg.sv
// Shared constants for the MEM-stage I/O port block: region decode offsets and parameter limits.
package pipe_io_pkg;

  localparam int IO_BIT     = 7;
  localparam int OFF_OUT    = 0;
  localparam int OFF_IN     = 16;
  localparam int OFF_MASK   = 30;
  localparam int OFF_STATUS = 31;

  localparam int N_OUT_MAX    = 16;
  localparam int N_IN_MAX     = 14;
  localparam int SYNC_MIN     = 2;
  localparam int DEBOUNCE_MIN = 2;

  function automatic bit cfg_ok(int data_w, int n_out, int n_in, int sync_stages, int debounce_cyc);
    return (n_out >= 1) && (n_out <= N_OUT_MAX) &&
           (n_in >= 1) && (n_in <= N_IN_MAX) && (n_in <= data_w) &&
           (sync_stages >= SYNC_MIN) && (debounce_cyc >= DEBOUNCE_MIN);
  endfunction

endpackage

// File: rtl/pipe_in_sync.sv
// One input channel: synchroniser chain, optional debouncer (IO_DEBOUNCE_EN) and change pulse.
module pipe_in_sync #(
  parameter int W      = 32,
  parameter int STAGES = 2
`ifdef IO_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYC = 16
`endif
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic         chg
);

  logic [STAGES-1:0][W-1:0] chain;
  logic [W-1:0]             raw;
  logic [W-1:0]             sync_w;
  logic [W-1:0]             prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], din};
  end

  assign raw = chain[STAGES-1];

`ifdef IO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;

  logic [W-1:0]  raw_q;
  logic [W-1:0]  sync_q;
  logic [CW-1:0] cnt;

  // cnt tracks how many consecutive edges raw has shown one value that differs from sync_q
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raw_q  <= '0;
      sync_q <= '0;
      cnt    <= '0;
    end else begin
      raw_q <= raw;
      if (raw == sync_q)                     cnt <= '0;
      else if (raw != raw_q)                 cnt <= CW'(1);
      else if (cnt >= CW'(DEBOUNCE_CYC - 1)) begin
        sync_q <= raw;
        cnt    <= '0;
      end else                               cnt <= cnt + 1'b1;
    end
  end

  assign sync_w = sync_q;
`else
  assign sync_w = raw;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev_q <= '0;
    else       prev_q <= sync_w;
  end

  assign sync = sync_w;
  assign chg  = (sync_w != prev_q);

endmodule

// File: rtl/pipe_mmio_ports.sv
// MEM-stage memory-mapped I/O: N_OUT output registers, N_IN synchronised inputs with sticky
// change status, mask and irq. Optional input debounce via IO_DEBOUNCE_EN.
module pipe_mmio_ports
  import pipe_io_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int N_OUT        = 3,
  parameter int N_IN         = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic                     re,
  input  logic [31:0]              addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     io_hit,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic [N_OUT*DATA_W-1:0]  out_port,
  input  logic [N_IN*DATA_W-1:0]   in_port,
  output logic                     irq
);

  if (!cfg_ok(DATA_W, N_OUT, N_IN, SYNC_STAGES, DEBOUNCE_CYC)) begin : g_bad_cfg
    $error("pipe_mmio_ports: parameter out of range");
  end

  logic [4:0]                   off;
  logic                         wr_acc;
  logic                         rd_acc;
  logic [N_OUT-1:0][DATA_W-1:0] out_q;
  logic [N_IN-1:0][DATA_W-1:0]  sync_v;
  logic [N_IN-1:0]              chg;
  logic [N_IN-1:0]              mask_q;
  logic [N_IN-1:0]              status_q;
  logic [N_IN-1:0]              clr;
  logic [DATA_W-1:0]            rd_mux;
  logic                         unused_addr_lsb;

  assign io_hit          = (addr[31:8] == 24'd0) && addr[IO_BIT];
  assign off             = addr[6:2];
  assign unused_addr_lsb = ^addr[1:0];
  assign wr_acc          = io_hit && we;
  assign rd_acc          = io_hit && re;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    pipe_in_sync #(
      .W      (DATA_W),
      .STAGES (SYNC_STAGES)
`ifdef IO_DEBOUNCE_EN
      , .DEBOUNCE_CYC (DEBOUNCE_CYC)
`endif
    ) u_in (
      .clock (clock),
      .reset (reset),
      .din   (in_port[i*DATA_W +: DATA_W]),
      .sync  (sync_v[i]),
      .chg   (chg[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_OUT; i++)
      if (off == 5'(OFF_OUT + i)) rd_mux = out_q[i];
    for (int i = 0; i < N_IN; i++)
      if (off == 5'(OFF_IN + i)) rd_mux = sync_v[i];
    if (off == 5'(OFF_MASK))   rd_mux = DATA_W'(mask_q);
    if (off == 5'(OFF_STATUS)) rd_mux = DATA_W'(status_q);
  end

  assign clr = (wr_acc && off == 5'(OFF_STATUS)) ? wdata[N_IN-1:0] : '0;

  // rd_mux is sampled from pre-edge state, so a same-cycle write to the read offset returns the old value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q    <= '0;
      mask_q   <= '0;
      status_q <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
    end else begin
      for (int i = 0; i < N_OUT; i++)
        if (wr_acc && off == 5'(OFF_OUT + i)) out_q[i] <= wdata;
      if (wr_acc && off == 5'(OFF_MASK)) mask_q <= wdata[N_IN-1:0];
      status_q <= (status_q & ~clr) | chg;
      rvalid   <= rd_acc;
      if (rd_acc) rdata <= rd_mux;
    end
  end

  assign out_port = out_q;
  assign irq      = |(status_q & mask_q);

endmodule

// File: tb/tb_pipe_mmio_ports.sv
// Bench for pipe_mmio_ports: word-level reference model compared every cycle plus directed literal checks.
module tb_pipe_mmio_ports;

  localparam int DW = 32;
  localparam int NO = 3;
  localparam int NI = 2;
  localparam int SS = 2;
  localparam int DB = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              we, re;
  logic [31:0]       addr;
  logic [DW-1:0]     wdata;
  logic              io_hit;
  logic [DW-1:0]     rdata;
  logic              rvalid;
  logic [NO*DW-1:0]  out_port;
  logic [NI*DW-1:0]  in_port;
  logic              irq;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 0;

  pipe_mmio_ports #(
    .DATA_W(DW), .N_OUT(NO), .N_IN(NI), .SYNC_STAGES(SS), .DEBOUNCE_CYC(DB)
  ) dut (
    .clock(clock), .reset(reset), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .io_hit(io_hit), .rdata(rdata), .rvalid(rvalid), .out_port(out_port),
    .in_port(in_port), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference model: word registers, a sample-delay queue for the synchroniser, a window for debounce
  logic [DW-1:0]    m_out [NO];
  logic [DW-1:0]    m_sync [NI];
  logic [DW-1:0]    m_prev [NI];
  logic [NI-1:0]    m_mask, m_status, m_set, m_clr;
  logic [DW-1:0]    m_rdata;
  logic             m_rvalid;
  logic [NI*DW-1:0] m_rawf;
  logic [NI*DW-1:0] m_q [$];
  logic [NI*DW-1:0] m_dq [$];
  logic             m_hit;
  int               m_off;

  function automatic logic [DW-1:0] m_read(input int o);
    if (o < NO) return m_out[o];
    if (o >= 16 && o < 16 + NI) return m_sync[o-16];
    if (o == 30) return DW'(m_mask);
    if (o == 31) return DW'(m_status);
    return '0;
  endfunction

  function automatic logic [NO*DW-1:0] m_outflat();
    logic [NO*DW-1:0] f;
    for (int i = 0; i < NO; i++) f[i*DW +: DW] = m_out[i];
    return f;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NO; i++) m_out[i] = '0;
      for (int i = 0; i < NI; i++) begin m_sync[i] = '0; m_prev[i] = '0; end
      m_mask = '0; m_status = '0; m_rdata = '0; m_rvalid = 0; m_rawf = '0;
      m_q = {};
      for (int i = 0; i < SS - 1; i++) m_q.push_back('0);
      m_dq = {};
      for (int i = 0; i < DB; i++) m_dq.push_back('0);
    end else begin
      m_hit = (addr >= 32'h80) && (addr <= 32'hFF);
      m_off = int'((addr - 32'h80) >> 2);
      if (m_hit && re) begin m_rdata = m_read(m_off); m_rvalid = 1; end
      else m_rvalid = 0;
      for (int i = 0; i < NI; i++) m_set[i] = (m_sync[i] != m_prev[i]);
      m_clr = (m_hit && we && m_off == 31) ? wdata[NI-1:0] : '0;
      if (m_hit && we && m_off < NO) m_out[m_off] = wdata;
      if (m_hit && we && m_off == 30) m_mask = wdata[NI-1:0];
      m_status = (m_status & ~m_clr) | m_set;
      for (int i = 0; i < NI; i++) m_prev[i] = m_sync[i];
`ifdef IO_DEBOUNCE_EN
      m_dq.push_back(m_rawf);
      void'(m_dq.pop_front());
      for (int i = 0; i < NI; i++) begin
        logic [DW-1:0] v;
        bit same;
        v = m_dq[0][i*DW +: DW];
        same = 1;
        foreach (m_dq[k]) if (m_dq[k][i*DW +: DW] != v) same = 0;
        if (same && v != m_sync[i]) m_sync[i] = v;
      end
`endif
      m_q.push_back(in_port);
      m_rawf = m_q.pop_front();
`ifndef IO_DEBOUNCE_EN
      for (int i = 0; i < NI; i++) m_sync[i] = m_rawf[i*DW +: DW];
`endif
    end
  end

  always @(negedge clock) begin
    if (run_cmp) begin
      chk("io_hit",   io_hit,   (addr >= 32'h80) && (addr <= 32'hFF));
      chk("rvalid",   rvalid,   m_rvalid);
      chk("rdata",    rdata,    m_rdata);
      chk("out_port", out_port, m_outflat());
      chk("irq",      irq,      |(m_status & m_mask));
    end
  end

  task automatic st(input logic [31:0] a, input logic [DW-1:0] d);
    addr = a; wdata = d; we = 1;
    @(posedge clock); #2;
    we = 0;
  endtask

  task automatic ld(input logic [31:0] a);
    addr = a; re = 1;
    @(posedge clock); #2;
    re = 0;
  endtask

  task automatic look();
    @(negedge clock); #1;
  endtask

  initial begin
    reset = 1; we = 0; re = 0; addr = '0; wdata = '0; in_port = '0;
    repeat (2) @(posedge clock);
    #2 reset = 0;
    run_cmp = 1;
    look();
    chk("reset out_port", out_port, '0);
    chk("reset rvalid", rvalid, 0);
    chk("reset irq", irq, 0);
    chk("reset rdata", rdata, '0);

    st(32'h84, 32'hA5); look();
    chk("out ch1", out_port[63:32], 32'hA5);
    chk("out ch0", out_port[31:0], 32'h0);
    chk("out ch2", out_port[95:64], 32'h0);

    in_port[31:0] = 32'h1234;
    repeat (3) @(posedge clock); #2;
    ld(32'hC0); look();
    chk("in0 rvalid", rvalid, 1);
    chk("in0 rdata", rdata, 32'h1234);
    look();
    chk("rvalid one cycle", rvalid, 0);
    ld(32'hFC); look();
    chk("status after change", rdata, 32'h1);

    st(32'hF8, 32'h1); look();
    chk("irq masked on", irq, 1);
    st(32'hFC, 32'h1); look();
    chk("irq after w1c", irq, 0);
    ld(32'hFC); look();
    chk("status after w1c", rdata, 32'h0);

    in_port[31:0] = 32'h5678;
    @(posedge clock); #2;
    @(posedge clock); #2;
    st(32'hFC, 32'h1); look();
    chk("set wins irq", irq, 1);
    ld(32'hFC); look();
    chk("set wins status", rdata, 32'h1);
    st(32'hFC, 32'h1); look();
    chk("irq cleared again", irq, 0);

    ld(32'h94); look();
    chk("unmapped rdata", rdata, 32'h0);
    chk("unmapped rvalid", rvalid, 1);
    addr = 32'h100; re = 1; look();
    chk("0x100 io_hit", io_hit, 0);
    @(posedge clock); #2; re = 0; look();
    chk("0x100 rvalid", rvalid, 0);
    st(32'h90, 32'hDEAD); look();
    chk("unmapped write", out_port, {32'h0, 32'hA5, 32'h0});

    addr = 32'h84; wdata = 32'h77; we = 1; re = 1;
    @(posedge clock); #2; we = 0; re = 0; look();
    chk("rw same rdata", rdata, 32'hA5);
    chk("rw same out", out_port[63:32], 32'h77);

    st(32'h80, '1); st(32'h84, '1); st(32'h88, '1); st(32'hF8, 32'h3); look();
    chk("all ones", out_port, {96{1'b1}});
    addr = 32'h80; wdata = 32'h12345678; we = 1; re = 1;
    #1 reset = 1; #1;
    chk("rst out_port", out_port, '0);
    chk("rst irq", irq, 0);
    chk("rst rvalid", rvalid, 0);
    chk("rst rdata", rdata, '0);
    we = 0; re = 0;
    repeat (2) @(posedge clock); #2 reset = 0;
    ld(32'hFC); look();
    chk("no status after release", rdata, 32'h0);
    repeat (4) @(posedge clock); #2;
    ld(32'hFC); look();
    chk("held input sets status", rdata, 32'h1);

`ifdef IO_DEBOUNCE_EN
    in_port[63:32] = 32'hBEEF;
    repeat (3) @(posedge clock); #2;
    in_port[63:32] = 32'h0;
    repeat (8) @(posedge clock); #2;
    ld(32'hC4); look();
    chk("db glitch rdata", rdata, 32'h0);
    ld(32'hFC); look();
    chk("db glitch status", rdata[1], 0);
    in_port[63:32] = 32'hBEEF;
    repeat (8) @(posedge clock); #2;
    ld(32'hC4); look();
    chk("db stable rdata", rdata, 32'hBEEF);
    ld(32'hFC); look();
    chk("db stable status", rdata[1], 1);
`endif

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
